sobel_stream_core: RTL and testbench

SOBEL_STREAM_CORE -- requirements
Module: sobel_stream_core

---
 rtl/sobel_stream_core.sv | 161 ++++++++++++++++
 tb/tb_sobel_stream_core.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel edge filter with valid/ready handshake on both sides.
// Two line buffers plus a two-column window feed one registered output stage.
module sobel_stream_core #(
  parameter int PIXEL_WIDTH = 8,
  parameter int LINE_WIDTH  = 16,
  parameter int FRAME_LINES = 16
) (
  input  logic                   clk_i,
  input  logic                   nreset_i,
  input  logic [1:0]             select_i,
  input  logic                   start_i,
  input  logic [PIXEL_WIDTH-1:0] in_pixel_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [PIXEL_WIDTH-1:0] out_pixel_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   busy_o,
  output logic                   frame_done_o
);

  localparam int CW = $clog2(LINE_WIDTH);
  localparam int RW = $clog2(FRAME_LINES);
  localparam int SW = PIXEL_WIDTH + 3;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam logic [CW-1:0]          COL_LAST = CW'(LINE_WIDTH - 1);
  localparam logic [RW-1:0]          ROW_LAST = RW'(FRAME_LINES - 1);
  localparam logic [PIXEL_WIDTH-1:0] PIX_MAX  = '1;

  logic [1:0]             state_q, state_d;
  logic [CW-1:0]          col_q, col_d;
  logic [RW-1:0]          row_q, row_d;
  logic [1:0]             mode_q, mode_d;
  logic                   out_valid_q, out_valid_d;
  logic [PIXEL_WIDTH-1:0] out_pixel_q, out_pixel_d;

  logic [PIXEL_WIDTH-1:0] lb0_q [LINE_WIDTH];
  logic [PIXEL_WIDTH-1:0] lb1_q [LINE_WIDTH];
  logic [PIXEL_WIDTH-1:0] win_q [3][2];
  logic [PIXEL_WIDTH-1:0] w     [3][3];

  logic                   in_acc, out_xfer, last_px;
  logic signed [SW-1:0]   gx, gy;
  logic [SW-1:0]          abs_x, abs_y;
  logic [SW:0]            sum_xy;
  logic [PIXEL_WIDTH-1:0] sat_x, sat_y, sat_xy, result;

  function automatic logic signed [SW-1:0] ext(input logic [PIXEL_WIDTH-1:0] p);
    return $signed({3'b000, p});
  endfunction

  assign in_ready_o   = (state_q == S_RUN) & (~out_valid_q | out_ready_i);
  assign in_acc       = in_valid_i & in_ready_o;
  assign out_xfer     = out_valid_q & out_ready_i;
  assign last_px      = (col_q == COL_LAST) & (row_q == ROW_LAST);
  assign out_valid_o  = out_valid_q;
  assign out_pixel_o  = out_pixel_q;
  assign busy_o       = (state_q != S_IDLE);
  assign frame_done_o = (state_q == S_FLUSH) & out_xfer;

  // Window columns c-2 and c-1 come from registers; column c is the live input.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      w[i][0] = win_q[i][0];
      w[i][1] = win_q[i][1];
    end
    w[0][2] = lb0_q[col_q];
    w[1][2] = lb1_q[col_q];
    w[2][2] = in_pixel_i;
  end

  always_comb begin
    gx = ext(w[0][2]) + (ext(w[1][2]) <<< 1) + ext(w[2][2])
       - ext(w[0][0]) - (ext(w[1][0]) <<< 1) - ext(w[2][0]);
    gy = ext(w[2][0]) + (ext(w[2][1]) <<< 1) + ext(w[2][2])
       - ext(w[0][0]) - (ext(w[0][1]) <<< 1) - ext(w[0][2]);
    abs_x  = gx[SW-1] ? $unsigned(-gx) : $unsigned(gx);
    abs_y  = gy[SW-1] ? $unsigned(-gy) : $unsigned(gy);
    sum_xy = {1'b0, abs_x} + {1'b0, abs_y};
    sat_x  = (abs_x  > {3'b000,  PIX_MAX}) ? PIX_MAX : abs_x[PIXEL_WIDTH-1:0];
    sat_y  = (abs_y  > {3'b000,  PIX_MAX}) ? PIX_MAX : abs_y[PIXEL_WIDTH-1:0];
    sat_xy = (sum_xy > {4'b0000, PIX_MAX}) ? PIX_MAX : sum_xy[PIXEL_WIDTH-1:0];
    result = '0;
    if (mode_q == 2'b00) begin
      result = in_pixel_i;
    end else if ((row_q >= RW'(2)) && (col_q >= CW'(2))) begin
      case (mode_q)
        2'b01:   result = sat_x;
        2'b10:   result = sat_y;
        default: result = sat_xy;
      endcase
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_pixel_d = out_pixel_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        state_d = S_RUN;
        col_d   = '0;
        row_d   = '0;
        mode_d  = select_i;
      end
      S_RUN:   if (in_acc && last_px) state_d = S_FLUSH;
      S_FLUSH: if (out_xfer) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (in_acc) begin
      out_valid_d = 1'b1;
      out_pixel_d = result;
      if (col_q == COL_LAST) begin
        col_d = '0;
        if (row_q != ROW_LAST) row_d = row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else if (out_xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      state_q     <= S_IDLE;
      col_q       <= '0;
      row_q       <= '0;
      mode_q      <= 2'b00;
      out_valid_q <= 1'b0;
      out_pixel_q <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_pixel_q <= out_pixel_d;
    end
  end

  // Pixel storage carries no reset; border outputs never depend on stale data.
  always_ff @(posedge clk_i) begin
    if (in_acc) begin
      lb0_q[col_q] <= lb1_q[col_q];
      lb1_q[col_q] <= in_pixel_i;
      for (int i = 0; i < 3; i++) begin
        win_q[i][0] <= win_q[i][1];
        win_q[i][1] <= w[i][2];
      end
    end
  end

endmodule

// File: tb/tb_sobel_stream_core.sv
// Directed self-checking bench for sobel_stream_core on a 4x4 frame of 8-bit pixels.
module tb_sobel_stream_core;

  localparam int PW   = 8;
  localparam int LW   = 4;
  localparam int FL   = 4;
  localparam int NPIX = LW * FL;

  logic          clk_i;
  logic          nreset_i;
  logic [1:0]    select_i;
  logic          start_i;
  logic [PW-1:0] in_pixel_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [PW-1:0] out_pixel_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          busy_o;
  logic          frame_done_o;

  int            checks = 0;
  int            errors = 0;
  logic [PW-1:0] frame_px [NPIX];
  logic [PW-1:0] exp_px   [NPIX];
  logic [PW-1:0] mon_q [$];
  int            done_cnt = 0;
  int            done_idx = 0;
  bit            mon_en   = 1'b0;

  sobel_stream_core #(
    .PIXEL_WIDTH(PW),
    .LINE_WIDTH (LW),
    .FRAME_LINES(FL)
  ) dut (
    .clk_i       (clk_i),
    .nreset_i    (nreset_i),
    .select_i    (select_i),
    .start_i     (start_i),
    .in_pixel_i  (in_pixel_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .out_pixel_o (out_pixel_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o),
    .frame_done_o(frame_done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Output transfers are recorded mid-low-phase, clear of both clock edges.
  always begin
    @(negedge clk_i);
    #2;
    if (mon_en && nreset_i && out_valid_o && out_ready_i) mon_q.push_back(out_pixel_o);
    if (mon_en && frame_done_o) begin
      done_cnt++;
      done_idx = mon_q.size();
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic waitReady();
    int guard = 0;
    #1;
    while (!in_ready_o && guard < 20) begin
      @(negedge clk_i);
      #1;
      guard++;
    end
    if (guard >= 20) checkOutput("in_ready_timeout", 32'd0, 32'd1);
  endtask

  task automatic applyStimulus(input logic [1:0] mode, input int stall_at, input bit toggle_start);
    int guard;
    mon_q.delete();
    done_cnt = 0;
    done_idx = 0;
    @(negedge clk_i);
    start_i  = 1'b1;
    select_i = mode;
    @(negedge clk_i);
    start_i  = 1'b0;
    select_i = ~mode;
    checkOutput("busy_run", busy_o, 1);
    for (int k = 0; k < NPIX; k++) begin
      in_pixel_i = frame_px[k];
      in_valid_i = 1'b1;
      start_i    = toggle_start && (k % 3 == 1);
      if (k == stall_at) begin
        out_ready_i = 1'b0;
        repeat (5) begin
          @(negedge clk_i);
          checkOutput("stall_ready", in_ready_o, 0);
          checkOutput("stall_valid", out_valid_o, 1);
          checkOutput("stall_hold", out_pixel_o, frame_px[k-1]);
        end
        out_ready_i = 1'b1;
      end
      waitReady();
      @(negedge clk_i);
      if (mode == 2'b00) checkOutput("latency", out_pixel_o, frame_px[k]);
    end
    in_valid_i = 1'b0;
    start_i    = 1'b0;
    guard = 0;
    while (busy_o && guard < 20) begin
      @(negedge clk_i);
      guard++;
    end
    checkOutput("busy_drop_cycles", guard, 1);
    checkOutput("idle_valid", out_valid_o, 0);
    checkOutput("out_count", mon_q.size(), NPIX);
    for (int k = 0; k < NPIX; k++) begin
      if (k < mon_q.size()) checkOutput("pixel", mon_q[k], exp_px[k]);
    end
    checkOutput("done_count", done_cnt, 1);
    checkOutput("done_index", done_idx, NPIX);
  endtask

  initial begin
    nreset_i    = 1'b0;
    select_i    = 2'b00;
    start_i     = 1'b0;
    in_pixel_i  = '0;
    in_valid_i  = 1'b0;
    out_ready_i = 1'b1;
    #12;
    checkOutput("rst_valid", out_valid_o, 0);
    checkOutput("rst_pixel", out_pixel_o, 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_ready", in_ready_o, 0);
    checkOutput("rst_done", frame_done_o, 0);
    nreset_i = 1'b1;
    mon_en   = 1'b1;

    for (int k = 0; k < NPIX; k++) begin frame_px[k] = PW'(k); exp_px[k] = PW'(k); end
    applyStimulus(2'b00, -1, 1'b0);

    for (int k = 0; k < NPIX; k++) begin frame_px[k] = 8'd100; exp_px[k] = 8'd0; end
    applyStimulus(2'b11, -1, 1'b0);

    for (int k = 0; k < NPIX; k++) begin
      frame_px[k] = ((k % LW) >= 2) ? 8'd255 : 8'd0;
      exp_px[k]   = ((k / LW) >= 2 && (k % LW) >= 2) ? 8'd255 : 8'd0;
    end
    applyStimulus(2'b01, -1, 1'b0);
    for (int k = 0; k < NPIX; k++) exp_px[k] = 8'd0;
    applyStimulus(2'b10, -1, 1'b0);

    for (int k = 0; k < NPIX; k++) begin frame_px[k] = PW'(100 + k); exp_px[k] = PW'(100 + k); end
    applyStimulus(2'b00, 6, 1'b0);

    for (int k = 0; k < NPIX; k++) begin
      frame_px[k] = PW'(10 * (k / LW) + 5 * (k % LW));
      exp_px[k]   = ((k / LW) >= 2 && (k % LW) >= 2) ? 8'd120 : 8'd0;
    end
    applyStimulus(2'b11, -1, 1'b1);
    for (int k = 0; k < NPIX; k++) exp_px[k] = ((k / LW) >= 2 && (k % LW) >= 2) ? 8'd40 : 8'd0;
    applyStimulus(2'b01, -1, 1'b0);

    for (int k = 0; k < NPIX; k++) begin
      frame_px[k] = PW'(50 - 10 * (k / LW));
      exp_px[k]   = ((k / LW) >= 2 && (k % LW) >= 2) ? 8'd80 : 8'd0;
    end
    applyStimulus(2'b10, -1, 1'b0);

    // Abort a frame with reset after seven accepted pixels.
    done_cnt = 0;
    @(negedge clk_i);
    start_i  = 1'b1;
    select_i = 2'b00;
    @(negedge clk_i);
    start_i  = 1'b0;
    for (int k = 0; k < 7; k++) begin
      in_pixel_i = PW'(k + 1);
      in_valid_i = 1'b1;
      waitReady();
      @(negedge clk_i);
    end
    #1;
    nreset_i = 1'b0;
    #1;
    checkOutput("abort_valid", out_valid_o, 0);
    checkOutput("abort_pixel", out_pixel_o, 0);
    checkOutput("abort_busy", busy_o, 0);
    checkOutput("abort_ready", in_ready_o, 0);
    checkOutput("abort_done", frame_done_o, 0);
    in_valid_i = 1'b0;
    @(negedge clk_i);
    nreset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("no_restart", busy_o, 0);
    checkOutput("abort_no_done", done_cnt, 0);

    for (int k = 0; k < NPIX; k++) begin frame_px[k] = PW'(200 + k); exp_px[k] = PW'(200 + k); end
    applyStimulus(2'b00, -1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
